adder_arbiter: RTL and testbench

Round-robin scheduler that shares one combinational `ADDER` instance between `NREQ` requesters (PC-increment, branch-target, address-generation units, etc.). Requesters present operand pairs with a valid/ready handshake. The arbiter muxes the winner's operands onto the adder and registers the sum with the requester ID. It holds the result on a response channel until the consumer accepts it, sustaining one addition per cycle under back-pressure-free operation.

---
 rtl/adder_arbiter_if.sv | 39 +++
 rtl/adder_arbiter.sv | 116 +++++++++++
 tb/tb_adder_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_arbiter_if.sv
// rtl/adder_arbiter_if.sv - request, shared-adder and response signals of adder_arbiter
// ADDER_ARB_CARRY_EN adds the rsp_carry response bit.
interface adder_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic [WIDTH-1:0]      add_y;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_data;
`ifdef ADDER_ARB_CARRY_EN
    logic                  rsp_carry;
`endif

    modport slave (
        input  req_valid, req_a, req_b, add_y, rsp_ready,
`ifdef ADDER_ARB_CARRY_EN
        output rsp_carry,
`endif
        output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output req_valid, req_a, req_b, add_y, rsp_ready,
`ifdef ADDER_ARB_CARRY_EN
        input  rsp_carry,
`endif
        input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin scheduler sharing one combinational adder between NREQ requesters
// Define ADDER_ARB_CARRY_EN to register the adder carry-out as rsp_carry.
module adder_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
) (
    input  logic           clk,
    input  logic           rst,
    adder_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   prio_q, prio_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
`ifdef ADDER_ARB_CARRY_EN
    logic             rsp_carry_q, rsp_carry_d;
`endif

    logic             found;
    logic [IDW-1:0]   grant;
    logic [IDW-1:0]   idx_v;
    int               idx;
    logic             can_issue;
    logic             issue;
    logic [NREQ-1:0]  req_ready_v;
    logic [WIDTH-1:0] add_a_v, add_b_v;

    // Scan from the priority pointer upward, wrapping at NREQ.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = 0;
        idx_v = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(prio_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_v = IDW'(idx);
            if (!found && bus.req_valid[idx_v]) begin
                found = 1'b1;
                grant = idx_v;
            end
        end
    end

    assign can_issue = (state_q == EMPTY) || bus.rsp_ready;
    assign issue     = found && can_issue && !rst;

    // Idle or in reset, the adder inputs are parked at zero.
    always_comb begin
        req_ready_v = '0;
        add_a_v     = '0;
        add_b_v     = '0;
        if (issue) req_ready_v[grant] = 1'b1;
        if (found && !rst) begin
            add_a_v = bus.req_a[int'(grant)*WIDTH +: WIDTH];
            add_b_v = bus.req_b[int'(grant)*WIDTH +: WIDTH];
        end
    end

    assign bus.req_ready = req_ready_v;
    assign bus.add_a     = add_a_v;
    assign bus.add_b     = add_b_v;

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
`ifdef ADDER_ARB_CARRY_EN
        rsp_carry_d = rsp_carry_q;
`endif
        if (issue) begin
            state_d    = FULL;
            rsp_id_d   = grant;
            rsp_data_d = bus.add_y;
            prio_d     = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
`ifdef ADDER_ARB_CARRY_EN
            rsp_carry_d = (add_a_v[WIDTH-1] & add_b_v[WIDTH-1]) |
                          ((add_a_v[WIDTH-1] | add_b_v[WIDTH-1]) & ~bus.add_y[WIDTH-1]);
`endif
        end else if (state_q == FULL && bus.rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            prio_q     <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
`ifdef ADDER_ARB_CARRY_EN
            rsp_carry_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
`ifdef ADDER_ARB_CARRY_EN
            rsp_carry_q <= rsp_carry_d;
`endif
        end
    end

    assign bus.rsp_valid = (state_q == FULL);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
`ifdef ADDER_ARB_CARRY_EN
    assign bus.rsp_carry = rsp_carry_q;
`endif
endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - randomized self-checking bench for adder_arbiter against a behavioural model
module tb_adder_arbiter;
    localparam int W   = 32;
    localparam int N   = 4;
    localparam int IDW = $clog2(N);

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    adder_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

    adder_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.add_y = bus.add_a + bus.add_b;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    int             m_prio;
    bit             m_full;
    logic [W-1:0]   m_data;
    logic [IDW-1:0] m_id;
    logic           m_carry;

    function automatic int model_grant();
        for (int k = 0; k < N; k++)
            if (bus.req_valid[(m_prio + k) % N]) return (m_prio + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int w;
        logic [N-1:0] r;
        w = model_grant();
        r = '0;
        if (!rst && w >= 0 && (!m_full || bus.rsp_ready)) r[w] = 1'b1;
        return r;
    endfunction

    function automatic logic [W-1:0] exp_opnd(input logic [N*W-1:0] v);
        int w;
        w = model_grant();
        if (rst || w < 0) return '0;
        return v[w*W +: W];
    endfunction

    task automatic tick();
        int w;
        logic [W:0] s;
        w = model_grant();
        if (rst) begin
            m_full = 0; m_prio = 0; m_data = '0; m_id = '0; m_carry = 1'b0;
        end else if (w >= 0 && (!m_full || bus.rsp_ready)) begin
            s = {1'b0, bus.req_a[w*W +: W]} + {1'b0, bus.req_b[w*W +: W]};
            m_data  = s[W-1:0];
            m_carry = s[W];
            m_id    = IDW'(w);
            m_full  = 1;
            m_prio  = (w + 1) % N;
        end else if (m_full && bus.rsp_ready) begin
            m_full = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_operands();
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*W +: W] = $urandom();
            bus.req_b[i*W +: W] = $urandom();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        randomize_operands();
        rst = 1'b1;
        #3;
        checks++; if (bus.req_ready !== '0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", bus.req_ready); end
        checks++; if (bus.add_a !== '0) begin failures++; $display("FAIL reset_add_a got=%h exp=0", bus.add_a); end
        checks++; if (bus.add_b !== '0) begin failures++; $display("FAIL reset_add_b got=%h exp=0", bus.add_b); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== '0) begin failures++; $display("FAIL reset_rsp_id got=%0d exp=0", bus.rsp_id); end
        checks++; if (bus.rsp_data !== '0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", bus.rsp_data); end
`ifdef ADDER_ARB_CARRY_EN
        checks++; if (bus.rsp_carry !== 1'b0) begin failures++; $display("FAIL reset_rsp_carry got=%b exp=0", bus.rsp_carry); end
`endif
        rst = 1'b0;
        bus.req_valid = '0;
    endtask

    task automatic test_single();
        bus.req_valid  = 4'b0001;
        bus.req_a[W-1:0] = 32'd5;
        bus.req_b[W-1:0] = 32'd7;
        bus.rsp_ready  = 1'b1;
        #3;
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL single_req_ready got=%b exp=0001", bus.req_ready); end
        checks++; if (bus.add_a !== 32'd5) begin failures++; $display("FAIL single_add_a got=%h exp=5", bus.add_a); end
        tick();
        bus.req_valid = '0;
        checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL single_rsp_valid got=%b exp=1", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 2'd0) begin failures++; $display("FAIL single_rsp_id got=%0d exp=0", bus.rsp_id); end
        checks++; if (bus.rsp_data !== 32'd12) begin failures++; $display("FAIL single_rsp_data got=%0d exp=12", bus.rsp_data); end
        #3;
        tick();
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", bus.rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] one;
        one = 1;
        do_reset();
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            randomize_operands();
            #3;
            checks++; if (bus.req_ready !== (one << (k % N))) begin failures++; $display("FAIL rr_grant[%0d] got=%b exp=%b", k, bus.req_ready, one << (k % N)); end
            checks++; if (bus.add_b !== bus.req_b[(k % N)*W +: W]) begin failures++; $display("FAIL rr_add_b[%0d] got=%h exp=%h", k, bus.add_b, bus.req_b[(k % N)*W +: W]); end
            tick();
            checks++; if (bus.rsp_id !== IDW'(k % N)) begin failures++; $display("FAIL rr_rsp_id[%0d] got=%0d exp=%0d", k, bus.rsp_id, k % N); end
            checks++; if (bus.rsp_data !== m_data) begin failures++; $display("FAIL rr_rsp_data[%0d] got=%h exp=%h", k, bus.rsp_data, m_data); end
        end
    endtask

    task automatic test_back_pressure();
        logic [W-1:0]   held_data;
        logic [IDW-1:0] held_id;
        held_data = m_data;
        held_id   = m_id;
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #3;
            checks++; if (bus.req_ready !== '0) begin failures++; $display("FAIL bp_req_ready[%0d] got=%b exp=0", k, bus.req_ready); end
            tick();
            checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_rsp_valid[%0d] got=%b exp=1", k, bus.rsp_valid); end
            checks++; if (bus.rsp_data !== held_data || bus.rsp_id !== held_id) begin failures++; $display("FAIL bp_hold[%0d] got=%0d/%h exp=%0d/%h", k, bus.rsp_id, bus.rsp_data, held_id, held_data); end
        end
        bus.rsp_ready = 1'b1;
        #3;
        checks++; if (bus.req_ready !== exp_ready() || bus.req_ready === '0) begin failures++; $display("FAIL bp_resume_ready got=%b exp=%b", bus.req_ready, exp_ready()); end
        tick();
        checks++; if (bus.rsp_id !== m_id || bus.rsp_data !== m_data) begin failures++; $display("FAIL bp_resume_rsp got=%0d/%h exp=%0d/%h", bus.rsp_id, bus.rsp_data, m_id, m_data); end
    endtask

    task automatic test_wrap();
        bus.req_valid = 4'b0100;
        bus.rsp_ready = 1'b1;
        bus.req_a[2*W +: W] = 32'hFFFF_FFFF;
        bus.req_b[2*W +: W] = 32'd2;
        #3;
        tick();
        checks++; if (bus.rsp_data !== 32'd1) begin failures++; $display("FAIL wrap_data got=%h exp=1", bus.rsp_data); end
`ifdef ADDER_ARB_CARRY_EN
        checks++; if (bus.rsp_carry !== 1'b1) begin failures++; $display("FAIL wrap_carry got=%b exp=1", bus.rsp_carry); end
`endif
        bus.req_a[2*W +: W] = 32'd1;
        bus.req_b[2*W +: W] = 32'd1;
        #3;
        tick();
        checks++; if (bus.rsp_data !== 32'd2) begin failures++; $display("FAIL small_data got=%h exp=2", bus.rsp_data); end
`ifdef ADDER_ARB_CARRY_EN
        checks++; if (bus.rsp_carry !== 1'b0) begin failures++; $display("FAIL small_carry got=%b exp=0", bus.rsp_carry); end
`endif
        bus.req_valid = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req_valid = 4'b0010;
        bus.rsp_ready = 1'b0;
        randomize_operands();
        #3;
        checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL mid_first_grant got=%b exp=0010", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL mid_full got=%b exp=1", bus.rsp_valid); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%b exp=0", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== '0) begin failures++; $display("FAIL mid_async_data got=%h exp=0", bus.rsp_data); end
        tick();
        rst = 1'b0;
        bus.req_valid = 4'b1001;
        bus.rsp_ready = 1'b1;
        #3;
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL mid_prio_restart got=%b exp=0001", bus.req_ready); end
        tick();
        checks++; if (bus.rsp_id !== 2'd0 || bus.rsp_data !== m_data) begin failures++; $display("FAIL mid_rsp got=%0d/%h exp=0/%h", bus.rsp_id, bus.rsp_data, m_data); end
    endtask

    task automatic test_random();
        logic [N-1:0] er;
        logic [N-1:0] ar;
        logic [N-1:0] prev_ready;
        int           waited[N];
        prev_ready = '0;
        for (int i = 0; i < N; i++) waited[i] = 0;
        bus.req_valid = '0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(bus.req_valid[i] && !prev_ready[i])) begin
                    bus.req_valid[i]    = ($urandom_range(0, 2) != 0);
                    bus.req_a[i*W +: W] = $urandom();
                    bus.req_b[i*W +: W] = $urandom();
                end
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            #3;
            er = exp_ready();
            ar = bus.req_ready;
            checks++; if (ar !== er) begin failures++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", c, ar, er); end
            checks++; if (bus.add_a !== exp_opnd(bus.req_a)) begin failures++; $display("FAIL rnd_add_a[%0d] got=%h exp=%h", c, bus.add_a, exp_opnd(bus.req_a)); end
            for (int i = 0; i < N; i++) begin
                if (ar[i]) begin
                    checks++; if (waited[i] > N - 1) begin failures++; $display("FAIL rnd_starve[%0d] req=%0d waited=%0d max=%0d", c, i, waited[i], N - 1); end
                    waited[i] = 0;
                end else if (!bus.req_valid[i]) begin
                    waited[i] = 0;
                end else if (ar !== '0) begin
                    waited[i]++;
                end
            end
            prev_ready = er;
            tick();
            checks++; if (bus.rsp_valid !== m_full) begin failures++; $display("FAIL rnd_rsp_valid[%0d] got=%b exp=%b", c, bus.rsp_valid, m_full); end
            if (m_full) begin
                checks++; if (bus.rsp_id !== m_id || bus.rsp_data !== m_data) begin failures++; $display("FAIL rnd_rsp[%0d] got=%0d/%h exp=%0d/%h", c, bus.rsp_id, bus.rsp_data, m_id, m_data); end
`ifdef ADDER_ARB_CARRY_EN
                checks++; if (bus.rsp_carry !== m_carry) begin failures++; $display("FAIL rnd_carry[%0d] got=%b exp=%b", c, bus.rsp_carry, m_carry); end
`endif
            end
        end
        bus.req_valid = '0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        m_prio = 0; m_full = 0; m_data = '0; m_id = '0; m_carry = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
